cordic_result_packer: RTL
=========================

Name: cordic_result_packer

Overview:
Downstream stage of the CORDIC rotation core. It captures each valid result pair (o_xcord/o_ycord, qualified by o_aux) into a small FIFO. It then serializes each result as a 6-byte frame onto a byte-wide valid/ready stream that feeds the UART transmitter. The block absorbs the burst rate of the CORDIC pipeline against the much slower UART byte rate, and reports dropped results.

Parameters:
OW, 13, width of the signed CORDIC result words; legal range 2..16.
DEPTH, 4, result FIFO depth in entries; power of two, ≥2.
SYNC_BYTE, 8'hA5, frame header byte.

Ports:
i_clk  in  1  system clock, all logic rising-edge.
i_reset  in  1  asynchronous, active-high reset.
i_enable  in  1  capture enable; when low, i_aux is ignored. Draining continues.
i_xcord  in  OW  signed X result from CORDIC.
i_ycord  in  OW  signed Y result from CORDIC.
i_aux  in  1  result-valid strobe from CORDIC, one cycle per result.
i_clr_ovf  in  1  synchronous clear of o_overflow and o_drop_count.
o_tx_data  out  8  byte to UART transmitter.
o_tx_valid  out  1  o_tx_data is valid.
i_tx_ready  in  1  transmitter accepts the byte; transfer = o_tx_valid & i_tx_ready.
o_busy  out  1  high while a frame is in progress or the FIFO is non-empty.
o_fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
o_overflow  out  1  sticky; set when a result was dropped.
o_drop_count  out  8  saturating count of dropped results.

Behaviour:
- Reset (async, i_reset=1):
  - FIFO empty, pointers 0, FSM in IDLE.
  - o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_fifo_count=0, o_overflow=0, o_drop_count=0.
  - Reset mid-frame abandons the frame; no partial bytes resume after release.
- Push:
  - Occurs when i_enable & i_aux at a rising edge. The entry is {i_xcord, i_ycord}.
  - If the FIFO is full and no pop occurs in the same cycle, the new result is dropped. o_overflow←1 and o_drop_count increments, saturating at 255. The FIFO contents are unchanged.
  - Simultaneous push and pop while full: the push is accepted and the count stays DEPTH.
- Width rule:
  - Each word is sign-extended to 16 bits; bits [15:OW] replicate bit OW-1.
  - XH/XL are the high/low bytes of extended X; YH/YL likewise for Y.
  - CSUM = XH ^ XL ^ YH ^ YL.
- Frame byte order: SYNC_BYTE, XH, XL, YH, YL, CSUM.
- FSM states: IDLE, SYNC, XH, XL, YH, YL, CSUM.
  - IDLE: if the FIFO is non-empty, pop the head into the frame register, go to SYNC, and register o_tx_valid=1, o_tx_data=SYNC_BYTE.
  - SYNC..YL: o_tx_data and o_tx_valid are held stable while i_tx_ready=0. On a transfer, advance to the next state and present the next byte on the following cycle.
  - CSUM: on transfer, if the FIFO is non-empty, pop and go directly to SYNC (back-to-back frames, no idle cycle). Otherwise go to IDLE with o_tx_valid=0.
- Latency: if i_aux is sampled at edge E0 with the FSM idle, the entry is written at E0. SYNC is presented (o_tx_valid=1) after E1.
  - With i_tx_ready held 1, a frame occupies exactly 6 cycles.
- Outputs are all registered.
- o_fifo_count reflects occupancy after each edge; the frame register is not counted.
- o_busy = (state≠IDLE) | (o_fifo_count≠0).
- i_clr_ovf clears o_overflow and o_drop_count. If a drop occurs in the same cycle, the drop wins: o_overflow=1, o_drop_count=1.
- Changes on i_xcord/i_ycord outside i_aux have no effect.

Test Plan:
- Single result, OW=13: x=2896, y=2896, i_aux 1 cycle, ready=1 → bytes A5,0B,50,0B,50,00 on consecutive cycles; first valid one cycle after push edge; then IDLE, o_busy=0.
- Negative sign extension: x=-4096, y=1 → bytes A5,F0,00,00,01,F1.
- Backpressure: drop ready for 3 cycles while XL is presented → o_tx_data=50, o_tx_valid=1 held stable for 3 cycles; exactly one XL transfer; frame completes correctly.
- Overflow, DEPTH=4: ready=0, 6 back-to-back i_aux pulses → frame register holds sample 1; o_fifo_count=4; o_overflow=1; o_drop_count=1. Releasing ready yields 5 back-to-back frames of samples 1–5 in order, with no gap between CSUM and the next SYNC.
- i_enable=0 with i_aux pulses → no push, o_fifo_count stays 0, no tx activity. i_clr_ovf after an overflow → o_overflow=0, o_drop_count=0.
- Reset asserted while YH is presented → o_tx_valid=0 and o_fifo_count=0 immediately (async). After release with no new i_aux, no bytes are emitted.

Source files
------------

// File: rtl/cordic_result_packer.sv
// cordic_result_packer: buffers CORDIC result pairs in a FIFO and sends each one as a 6-byte checksummed frame on a byte stream.
module cordic_result_packer #(
  parameter int OW = 13,
  parameter int DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [OW-1:0]            i_xcord,
  input  logic [OW-1:0]            i_ycord,
  input  logic                     i_aux,
  input  logic                     i_clr_ovf,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, SYNC, XH, XL, YH, YL, CSUM} state_t;
  state_t state;
  logic [2*OW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] fx, fy, hx, hy;
  logic xfer, pop, push_req, full, push, drop, leave;
  logic [AW:0] count_nxt;
  always_comb begin
    hx = 16'($signed(mem[rd_ptr][2*OW-1:OW]));
    hy = 16'($signed(mem[rd_ptr][OW-1:0]));
    xfer = o_tx_valid & i_tx_ready;
    pop = (o_fifo_count != '0) & ((state == IDLE) | ((state == CSUM) & xfer));
    full = o_fifo_count == (AW+1)'(DEPTH);
    push_req = i_enable & i_aux;
    push = push_req & (~full | pop);
    drop = push_req & full & ~pop;
    leave = (state == CSUM) & xfer & ~pop;
    count_nxt = o_fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {i_xcord, i_ycord};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fx <= '0;
      fy <= '0;
      o_tx_data <= '0;
      o_tx_valid <= 1'b0;
      o_busy <= 1'b0;
      o_fifo_count <= '0;
      o_overflow <= 1'b0;
      o_drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_fifo_count <= count_nxt;
      o_busy <= pop | ((state != IDLE) & ~leave) | (count_nxt != '0);
      // a drop in the same cycle as a clear leaves a count of exactly one
      if (drop) begin
        o_overflow <= 1'b1;
        o_drop_count <= i_clr_ovf ? 8'd1 : o_drop_count + {7'd0, o_drop_count != 8'hFF};
      end else if (i_clr_ovf) begin
        o_overflow <= 1'b0;
        o_drop_count <= '0;
      end
      if (pop) begin
        fx <= hx;
        fy <= hy;
        state <= SYNC;
        o_tx_valid <= 1'b1;
        o_tx_data <= SYNC_BYTE;
      end else if (xfer) begin
        case (state)
          SYNC: begin state <= XH; o_tx_data <= fx[15:8]; end
          XH: begin state <= XL; o_tx_data <= fx[7:0]; end
          XL: begin state <= YH; o_tx_data <= fy[15:8]; end
          YH: begin state <= YL; o_tx_data <= fy[7:0]; end
          YL: begin state <= CSUM; o_tx_data <= fx[15:8] ^ fx[7:0] ^ fy[15:8] ^ fy[7:0]; end
          default: begin state <= IDLE; o_tx_valid <= 1'b0; o_tx_data <= '0; end
        endcase
      end
    end
endmodule
